// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier (MULTU unit).
// Holds the operand width, the iteration count and the FSM state encoding.
package mult_pkg;

    // Operand width; the product is twice this. Only 8 is usable because
    // the ripple adder the datapath drives is fixed at 8 bits.
    localparam int WIDTH = 8;

    // One partial product is accumulated per multiplier bit.
    localparam int ITERS = WIDTH;

    // Counter width needed to count ITERS iterations (0 .. ITERS-1).
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

endpackage

// File: rtl/SomadorCompleto8b.sv
// Existing 8-bit ripple-carry adder from the datapath library.
// Produces the 8-bit sum of A and B plus the carry-out of the top bit.
module SomadorCompleto8b (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] S,
    output logic       Cout
);

    logic carry;

    // Ripple the carry from bit 0 upward, one full-adder stage per bit.
    always_comb begin
        S     = '0;
        carry = 1'b0;
        for (int i = 0; i < 8; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/multiplicador_seq_8b.sv
// Sequential 8x8 unsigned shift-and-add multiplier (MULTU unit).
// A start pulse in IDLE captures a/b; eight RUN iterations accumulate one
// partial product each through SomadorCompleto8b; DONE pulses done for one
// cycle with the registered 16-bit product.
// Optional feature: define MULT_ZERO_BYPASS_EN to skip straight to DONE with
// a zero product when either operand is zero at acceptance.
module multiplicador_seq_8b #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import mult_pkg::*;

    mult_state_t state;
    mult_state_t next_state;

    // Datapath registers: multiplicand, upper product half (acc) and the
    // multiplier that shifts out to become the lower product half.
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplr;
    logic [CNT_W-1:0]   cnt;

    // Control strobes decoded by the FSM.
    logic               accept;
    logic               last_iter;
    logic               zero_skip;

    // Adder interface and the shifted {acc, mplr} pair for the next step.
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry_out;
    logic [2*WIDTH-1:0] shifted;

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_skip = (a == '0) || (b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // The partial product is the multiplicand gated by the current LSB of
    // the multiplier; the adder carry-out becomes bit 15 after the shift so
    // no sum bit is ever dropped.
    assign addend  = mplr[0] ? mcand : '0;
    assign shifted = {carry_out, sum, mplr[WIDTH-1:1]};

    SomadorCompleto8b u_adder (
        .A    (acc),
        .B    (addend),
        .S    (sum),
        .Cout (carry_out)
    );

    // State register; reset returns to IDLE and abandons any multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the Moore outputs busy/done and the strobes
    // the datapath uses to load operands and latch the final product.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (zero_skip) begin
                        next_state = DONE;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(ITERS - 1)) begin
                    last_iter  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, one shift-and-add step per RUN cycle, and the
    // product register that only changes when a result is completed (or
    // forced to zero by the bypass), so it holds between multiplies.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc     <= '0;
            mplr    <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
            if (zero_skip) begin
                product <= '0;
            end
        end else if (state == RUN) begin
            {acc, mplr} <= shifted;
            cnt         <= cnt + 1'b1;
            if (last_iter) begin
                product <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_multiplicador_seq_8b.sv
// Self-checking bench for multiplicador_seq_8b.
// Expected products come from plain integer multiplication and expected
// latencies from the documented handshake timing. Honours
// MULT_ZERO_BYPASS_EN when the design is built with it.
module tb_multiplicador_seq_8b;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int total_checks;
    int bad_checks;

    // Result the product port should hold until the next multiply finishes.
    logic [15:0] last_product;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[6];

    multiplicador_seq_8b dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Cycles from the accepting edge until done is seen (counted in ticks).
    function automatic int exp_latency(input logic [7:0] ta, input logic [7:0] tb_op);
`ifdef MULT_ZERO_BYPASS_EN
        if (ta == 8'h00 || tb_op == 8'h00) return 1;
`endif
        return 9;
    endfunction

    // Presents operands with a one-cycle start pulse; returns just after
    // the accepting edge.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_op);
        a     = ta;
        b     = tb_op;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for done and checks busy, latency, product, the
    // single-cycle done pulse and that the product then holds.
    task automatic checkOutput(input string name, input logic [15:0] exp_p,
                               input int exp_lat);
        int n;
        n = 1;
        if (exp_lat > 1) begin
            check_value({name, "_prod_held"}, product, last_product);
        end
        while (done !== 1'b1 && n < 40) begin
            check_value({name, "_busy_run"}, busy, 1);
            tick();
            n++;
        end
        check_value({name, "_latency"}, n, exp_lat);
        check_value({name, "_product"}, product, exp_p);
        check_value({name, "_busy_done"}, busy, 0);
        last_product = exp_p;
        tick();
        check_value({name, "_done_drop"}, done, 0);
        check_value({name, "_prod_keep"}, product, exp_p);
    endtask

    initial begin
        int done_seen;
        logic [7:0] ra;
        logic [7:0] rb;
        int p;

        total_checks = 0;
        bad_checks   = 0;
        last_product = 16'h0000;

        vecs[0] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
        vecs[1] = '{a: 8'h0F, b: 8'h10, p: 16'h00F0};
        vecs[2] = '{a: 8'h80, b: 8'h02, p: 16'h0100};
        vecs[3] = '{a: 8'h00, b: 8'h37, p: 16'h0000};
        vecs[4] = '{a: 8'h01, b: 8'h01, p: 16'h0001};
        vecs[5] = '{a: 8'hC8, b: 8'h00, p: 16'h0000};

        // Reset for two cycles.
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check_value("reset_busy", busy, 0);
        check_value("reset_done", done, 0);
        check_value("reset_product", product, 16'h0000);

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d", i), vecs[i].p,
                        exp_latency(vecs[i].a, vecs[i].b));
        end

        // Start held high through a whole multiply; operands change after
        // acceptance without effect, and the second request is taken on
        // the first IDLE cycle after DONE.
        a     = 8'h03;
        b     = 8'h05;
        start = 1'b1;
        tick();
        a = 8'h02;
        b = 8'h07;
        checkOutput("held_first", 16'h000F, 9);
        check_value("held_idle_busy", busy, 0);
        tick();
        start = 1'b0;
        check_value("held_second_busy", busy, 1);
        checkOutput("held_second", 16'h000E, 9);

        // Reset in the middle of a multiply.
        applyStimulus(8'hAA, 8'h55);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_product = 16'h0000;
        check_value("midrst_busy", busy, 0);
        check_value("midrst_done", done, 0);
        check_value("midrst_product", product, 16'h0000);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        check_value("midrst_no_done", done_seen, 0);
        applyStimulus(8'h02, 8'h03);
        checkOutput("after_rst", 16'h0006, 9);

        // Randomized operands against plain integer multiplication.
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i % 8 == 3) ra = 8'h00;
            if (i % 8 == 6) rb = 8'h00;
            p = int'(ra) * int'(rb);
            applyStimulus(ra, rb);
            checkOutput($sformatf("rand%0d", i), 16'(p), exp_latency(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
